// File: rtl/scarv_cop_pmul_seq_pkg.sv
// Shared definitions for the sequential packed multiplier: pack width
// codes, FSM state encoding and pack-width decode helpers.
package scarv_cop_pmul_seq_pkg;

  localparam logic [2:0] SCARV_COP_PW_1  = 3'b001;
  localparam logic [2:0] SCARV_COP_PW_2  = 3'b010;
  localparam logic [2:0] SCARV_COP_PW_4  = 3'b100;
  localparam logic [2:0] SCARV_COP_PW_8  = 3'b101;
  localparam logic [2:0] SCARV_COP_PW_16 = 3'b110;

  // Lane-width select: 0..4 pick L = 32 >> sel, SEL_NONE marks an unsupported pw.
  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pmul_state_e;

  function automatic logic [2:0] pw_sel(input logic [2:0] pw);
    case (pw)
      SCARV_COP_PW_1:  pw_sel = 3'd0;
      SCARV_COP_PW_2:  pw_sel = 3'd1;
      SCARV_COP_PW_4:  pw_sel = 3'd2;
      SCARV_COP_PW_8:  pw_sel = 3'd3;
      SCARV_COP_PW_16: pw_sel = 3'd4;
      default:         pw_sel = SEL_NONE;
    endcase
  endfunction

  // Index of the last bit step for a lane width (L-1).
  function automatic logic [4:0] sel_last(input logic [2:0] sel);
    case (sel)
      3'd0:    sel_last = 5'd31;
      3'd1:    sel_last = 5'd15;
      3'd2:    sel_last = 5'd7;
      3'd3:    sel_last = 5'd3;
      3'd4:    sel_last = 5'd1;
      default: sel_last = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/scarv_cop_pmul_step.sv
// One shift-and-accumulate step for every lane at once. Each lane k holds
// a 2L-bit accumulator at acc[2L*k +: 2L]; the partial product for bit idx
// of b's lane is added (or XORed) into it without carries crossing lanes.
module scarv_cop_pmul_step
  import scarv_cop_pmul_seq_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  idx,
  input  logic [2:0]  sel,
  input  logic        ncarry,
  output logic [63:0] acc_nxt
);

  logic [4:0][63:0] addend_w;
  logic [4:0][63:0] msb_w;
  logic [63:0]      add;
  logic [63:0]      msb;

  // Per lane width: build the shifted partial products and lane-top masks.
  for (genvar w = 0; w < 5; w++) begin : g_w
    localparam int L = 32 >> w;
    for (genvar k = 0; k < 32 / L; k++) begin : g_lane
      assign addend_w[w][2*L*k +: 2*L] =
        b[L*k + int'(idx)] ? ({{L{1'b0}}, a[L*k +: L]} << idx) : '0;
      assign msb_w[w][2*L*k +: 2*L] = {1'b1, {(2*L-1){1'b0}}};
    end
  end

  // Pick the active lane width, then add with carries cut at lane tops:
  // low bits add normally, the top bit of each lane is folded in by XOR.
  always_comb begin
    add = '0;
    msb = '0;
    case (sel)
      3'd0: begin add = addend_w[0]; msb = msb_w[0]; end
      3'd1: begin add = addend_w[1]; msb = msb_w[1]; end
      3'd2: begin add = addend_w[2]; msb = msb_w[2]; end
      3'd3: begin add = addend_w[3]; msb = msb_w[3]; end
      3'd4: begin add = addend_w[4]; msb = msb_w[4]; end
      default: ;
    endcase
    if (ncarry) acc_nxt = acc ^ add;
    else        acc_nxt = ((acc & ~msb) + (add & ~msb)) ^ ((acc ^ add) & msb);
  end

endmodule

// File: rtl/scarv_cop_pmul_seq.sv
// Sequential packed multiplier (PMUL.L/H, PCLMUL.L/H). Captures operands on
// start, runs one bit step per cycle for L cycles, then returns the low or
// high half of every lane product with a one-cycle done pulse.
module scarv_cop_pmul_seq
  import scarv_cop_pmul_seq_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  pw,
  input  logic        high,
  input  logic        ncarry,
  output logic        done,
  output logic [31:0] result
);

  pmul_state_e state, state_nxt;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [63:0] acc_nxt;
  logic [31:0] a_q, b_q;
  logic [2:0]  sel_q;
  logic        high_q, ncarry_q;
  logic [31:0] res_sel;
  logic [4:0][31:0] res_w;

  scarv_cop_pmul_step u_step (
    .acc     (acc),
    .a       (a_q),
    .b       (b_q),
    .idx     (count),
    .sel     (sel_q),
    .ncarry  (ncarry_q),
    .acc_nxt (acc_nxt)
  );

  // Per lane width: pick the requested half of each 2L-bit lane product.
  for (genvar w = 0; w < 5; w++) begin : g_res
    localparam int L = 32 >> w;
    for (genvar k = 0; k < 32 / L; k++) begin : g_lane
      assign res_w[w][L*k +: L] = high_q ? acc[2*L*k + L +: L] : acc[2*L*k +: L];
    end
  end

  // Result mux; unsupported widths give zero.
  always_comb begin
    res_sel = '0;
    case (sel_q)
      3'd0: res_sel = res_w[0];
      3'd1: res_sel = res_w[1];
      3'd2: res_sel = res_w[2];
      3'd3: res_sel = res_w[3];
      3'd4: res_sel = res_w[4];
      default: ;
    endcase
  end

  // Next state: abort on dropped start in RUN, DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (pw_sel(pw) == SEL_NONE) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (!start)                        state_nxt = ST_IDLE;
        else if (count == sel_last(sel_q)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, capture, accumulate and registered result/done.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= SEL_NONE;
      high_q   <= 1'b0;
      ncarry_q <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == ST_DONE);
      case (state)
        ST_IDLE: if (start) begin
          a_q      <= a;
          b_q      <= b;
          sel_q    <= pw_sel(pw);
          high_q   <= high;
          ncarry_q <= ncarry;
          acc      <= '0;
          count    <= '0;
        end
        ST_RUN: if (start) begin
          acc   <= acc_nxt;
          count <= count + 5'd1;
        end
        ST_DONE: result <= res_sel;
        default: ;
      endcase
    end
  end

endmodule
